fxp_seq_divider: RTL and testbench
==================================

// Module: fxp_seq_divider
// PURPOSE
//  Parametrised signed fixed-point divider: restoring radix-2, one quotient bit/cycle, ready/valid on both sides.
//  Result is (num << SHIFT) / den, truncated toward zero, then saturated; SHIFT = OUT_FRAC - NUM_FRAC + DEN_FRAC.
//  Sits between the pixel-math datapath and the consumers of per-pixel ratios; a pass-through tag keeps results associated with requests.
// PARAMETERS
//  NUM_WIDTH  17  signed numerator width
//  NUM_FRAC    8  numerator fraction bits
//  DEN_WIDTH   9  signed denominator width
//  DEN_FRAC    0  denominator fraction bits
//  OUT_WIDTH  17  signed quotient width
//  OUT_FRAC    8  quotient fraction bits; elaboration error if SHIFT < 0
//  TAG_WIDTH   4  opaque request tag, returned unchanged
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          request valid
//  in_ready   out  1          high only in IDLE
//  in_num     in   NUM_WIDTH  signed numerator
//  in_den     in   DEN_WIDTH  signed denominator
//  in_tag     in   TAG_WIDTH  request tag
//  out_valid  out  1          result valid; held until out_ready
//  out_ready  in   1          consumer accepts result
//  out_quot   out  OUT_WIDTH  signed saturated quotient
//  out_tag    out  TAG_WIDTH  tag of this result
//  out_dbz    out  1          denominator was zero
//  out_ovf    out  1          result saturated (excluding dbz)
// BEHAVIOUR
//  States: IDLE -> DIVIDE -> FIX -> DONE -> IDLE. Zero-denominator path: IDLE -> DONE.
//  Reset: state=IDLE; out_valid, out_quot, out_tag, out_dbz, out_ovf = 0; in_ready=1 on the cycle after reset.
//  Accept occurs when in_valid & in_ready.
//   - Register |num| (NUM_WIDTH unsigned, so the most negative value is exact) and |den|.
//   - Register sign = num[MSB]^den[MSB], the tag, and count = NUM_WIDTH+SHIFT.
//  DIVIDE: one restoring step per cycle.
//   - Shift the remainder/dividend pair left by 1; if the upper part >= |den|, subtract and set the quotient LSB.
//   - Leave DIVIDE when count reaches 1.
//  FIX (1 cycle): apply sign.
//   - Positive magnitude > 2^(OUT_WIDTH-1)-1 saturates to max; negative magnitude > 2^(OUT_WIDTH-1) saturates to min.
//   - out_ovf=1 when either saturation occurs.
//  Latency: accept at cycle 0 -> out_valid at cycle NUM_WIDTH+SHIFT+2. Zero-denominator latency is 1 cycle.
//  den==0 result: out_dbz=1, out_ovf=0; quotient = max if num>0, min if num<0, 0 if num==0.
//  DONE: out_valid=1 and all out_* held stable until out_ready. On out_valid & out_ready -> IDLE and out_valid drops next cycle.
//  No accept in the same cycle as result handoff; throughput is one op per NUM_WIDTH+SHIFT+3 cycles minimum.
//  Inputs are sampled only at accept; changes on in_* afterwards are ignored.
//  Reset mid-operation aborts immediately with no result emitted.
//  Quotient register width is NUM_WIDTH+SHIFT; remainder width is DEN_WIDTH.
// CONFIGURATION
//  FXP_DIV_ROUND_EN defined:
//   - FIX rounds half away from zero: increment the magnitude when 2*remainder >= |den|, before sign and saturation.
//   - Latency unchanged.
//  FXP_DIV_ROUND_EN undefined: pure truncation toward zero.
// STRUCTURE
//  Package fxp_div_pkg holds:
//   - state encoding (IDLE/DIVIDE/FIX/DONE)
//   - function shift_amt(OUT_FRAC,NUM_FRAC,DEN_FRAC)
//   - saturation-limit constant functions for a given width
//  Sub-module fxp_div_step: combinational single restoring iteration, parametrised by quotient and remainder widths.
//  The top holds the FSM, counter, handshake, sign, round and saturate logic.
// TESTING (defaults: SHIFT=0, Q8.8 / int)
//  1. num=0x00300 (3.0), den=2 -> out_quot=0x00180 (1.5), dbz=0, ovf=0; out_valid exactly 19 cycles after accept.
//  2. num=-768, den=2 -> -384; num=768, den=-7 -> -109 without rounding, -110 with FXP_DIV_ROUND_EN.
//  3. Zero denominator: num=100, den=0 -> 0x0FFFF, dbz=1, 1-cycle latency; num=-5 -> 0x10000; num=0 -> 0.
//  4. num=-65536, den=-1 -> 0x0FFFF, ovf=1; num=-65536, den=1 -> 0x10000, ovf=0.
//  5. Hold out_ready=0 for 5 cycles -> out_valid, quot and tag stable, in_ready=0; tag 0xA returns as 0xA.
//  6. Reset asserted mid-DIVIDE -> next cycle in_ready=1, out_valid=0; a new request then completes correctly.

Source files
------------

// File: rtl/fxp_div_pkg.sv
// Shared definitions for the sequential fixed-point divider: FSM encoding,
// fraction-alignment shift and saturation limits.
package fxp_div_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_FIX    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Left shift of the numerator that aligns the quotient to OUT_FRAC.
  function automatic int shift_amt(input int out_frac, input int num_frac, input int den_frac);
    return out_frac - num_frac + den_frac;
  endfunction

  // Largest positive magnitude representable in a signed word of this width.
  function automatic logic [63:0] sat_max_mag(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Largest negative magnitude representable in a signed word of this width.
  function automatic logic [63:0] sat_min_mag(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring division iteration: shift the remainder/quotient pair left,
// subtract the divisor when it fits and record the quotient bit.
module fxp_div_step #(
  parameter int QW = 17,
  parameter int RW = 9
) (
  input  logic [RW-1:0] rem,
  input  logic [QW-1:0] quo,
  input  logic [RW-1:0] den,
  output logic [RW-1:0] rem_nxt,
  output logic [QW-1:0] quo_nxt
);

  logic [RW:0] upper;
  logic        ge;

  assign upper   = {rem, quo[QW-1]};
  assign ge      = (upper >= {1'b0, den});
  assign rem_nxt = ge ? RW'(upper - {1'b0, den}) : upper[RW-1:0];
  assign quo_nxt = {quo[QW-2:0], ge};

endmodule

// File: rtl/fxp_seq_divider.sv
// Signed fixed-point restoring divider, one quotient bit per cycle, with
// saturation and tag pass-through. Define FXP_DIV_ROUND_EN for round-half-away.
module fxp_seq_divider
  import fxp_div_pkg::*;
#(
  parameter int NUM_WIDTH = 17,
  parameter int NUM_FRAC  = 8,
  parameter int DEN_WIDTH = 9,
  parameter int DEN_FRAC  = 0,
  parameter int OUT_WIDTH = 17,
  parameter int OUT_FRAC  = 8,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] in_num,
  input  logic [DEN_WIDTH-1:0] in_den,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_quot,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_dbz,
  output logic                 out_ovf
);

  localparam int SHIFT = shift_amt(OUT_FRAC, NUM_FRAC, DEN_FRAC);
  localparam int QW    = NUM_WIDTH + SHIFT;
  localparam int RW    = DEN_WIDTH;
  localparam int MW    = QW + 1;
  localparam int CW    = $clog2(QW + 1);
  localparam logic [63:0] MAX_MAG = sat_max_mag(OUT_WIDTH);
  localparam logic [63:0] MIN_MAG = sat_min_mag(OUT_WIDTH);

  if (SHIFT < 0) begin : g_shift_chk
    $error("fxp_seq_divider: OUT_FRAC - NUM_FRAC + DEN_FRAC must be >= 0");
  end

  logic [1:0]           state;
  logic [QW-1:0]        quo;
  logic [RW-1:0]        rem;
  logic [RW-1:0]        den_mag;
  logic                 sign;
  logic [TAG_WIDTH-1:0] tag;
  logic [CW-1:0]        count;

  logic [NUM_WIDTH-1:0] num_mag_in;
  logic [RW-1:0]        den_mag_in;
  logic [RW-1:0]        rem_nxt;
  logic [QW-1:0]        quo_nxt;

  // Magnitudes are unsigned so the most negative input converts exactly.
  assign num_mag_in = in_num[NUM_WIDTH-1] ? (~in_num + NUM_WIDTH'(1)) : in_num;
  assign den_mag_in = in_den[DEN_WIDTH-1] ? (~in_den + RW'(1)) : in_den;
  assign in_ready   = (state == ST_IDLE);

  fxp_div_step #(.QW(QW), .RW(RW)) u_step (
    .rem     (rem),
    .quo     (quo),
    .den     (den_mag),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  logic                 round_inc;
  logic [MW-1:0]        mag;
  logic [63:0]          mag64;
  logic                 sat_pos, sat_neg;
  logic [OUT_WIDTH-1:0] quot_fix;
  logic [OUT_WIDTH-1:0] quot_dbz;

`ifdef FXP_DIV_ROUND_EN
  assign round_inc = ({rem, 1'b0} >= {1'b0, den_mag});
`else
  assign round_inc = 1'b0;
`endif

  // Rounding is applied to the magnitude before sign and saturation.
  assign mag     = {1'b0, quo} + MW'(round_inc);
  assign mag64   = 64'(mag);
  assign sat_pos = !sign && (mag64 > MAX_MAG);
  assign sat_neg =  sign && (mag64 > MIN_MAG);

  always_comb begin
    quot_fix = OUT_WIDTH'(mag64);
    if (sat_pos)      quot_fix = OUT_WIDTH'(MAX_MAG);
    else if (sat_neg) quot_fix = OUT_WIDTH'(MIN_MAG);
    else if (sign)    quot_fix = OUT_WIDTH'(~mag64 + 64'd1);
  end

  always_comb begin
    quot_dbz = '0;
    if (in_num[NUM_WIDTH-1]) quot_dbz = OUT_WIDTH'(MIN_MAG);
    else if (|in_num)        quot_dbz = OUT_WIDTH'(MAX_MAG);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      quo       <= '0;
      rem       <= '0;
      den_mag   <= '0;
      sign      <= 1'b0;
      tag       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_tag   <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            tag <= in_tag;
            if (in_den == '0) begin
              out_quot  <= quot_dbz;
              out_tag   <= in_tag;
              out_dbz   <= 1'b1;
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              quo     <= QW'(num_mag_in) << SHIFT;
              rem     <= '0;
              den_mag <= den_mag_in;
              sign    <= in_num[NUM_WIDTH-1] ^ in_den[DEN_WIDTH-1];
              count   <= CW'(QW);
              state   <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          out_quot  <= quot_fix;
          out_tag   <= tag;
          out_dbz   <= 1'b0;
          out_ovf   <= sat_pos | sat_neg;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Self-checking bench for fxp_seq_divider (default Q8.8 / integer config);
// expectations come from an integer-arithmetic reference model and constants.
module tb_fxp_seq_divider;

  localparam int NW = 17, DW = 9, OW = 17, TW = 4, SHIFT = 0;
  localparam int QW = NW + SHIFT;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [NW-1:0] in_num;
  logic [DW-1:0] in_den;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_quot;
  logic [TW-1:0] out_tag;
  logic          out_dbz, out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  fxp_seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_tag   (out_tag),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  // Reference: (num << SHIFT) / den on plain integers, optional round, then saturate.
  function automatic void model(input longint n, input longint d,
                                output logic [OW-1:0] q, output logic dbz, output logic ovf);
    longint maxv, minv, a, ma, md, m, r, res;
    bit neg;
    maxv = (longint'(1) << (OW - 1)) - 1;
    minv = -(longint'(1) << (OW - 1));
    ovf  = 1'b0;
    dbz  = 1'b0;
    if (d == 0) begin
      dbz = 1'b1;
      res = (n > 0) ? maxv : (n < 0) ? minv : 0;
    end else begin
      a   = n * (longint'(1) << SHIFT);
      neg = (a < 0) != (d < 0);
      ma  = (a < 0) ? -a : a;
      md  = (d < 0) ? -d : d;
      m   = ma / md;
      r   = ma % md;
`ifdef FXP_DIV_ROUND_EN
      if (2 * r >= md) m = m + 1;
`else
      if (r < 0) m = m + 1;
`endif
      res = neg ? -m : m;
      if (res > maxv) begin res = maxv; ovf = 1'b1; end
      if (res < minv) begin res = minv; ovf = 1'b1; end
    end
    q = res[OW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [NW-1:0] num, input logic [DW-1:0] den, input logic [TW-1:0] tag);
    int guard = 0;
    in_num = num; in_den = den; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    // Post-accept input changes must not disturb the operation in flight.
    in_num = NW'($urandom); in_den = DW'($urandom); in_tag = TW'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    n_tests++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL result_timeout out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_tests++; if (out_quot !== '0) begin n_fail++; $display("FAIL reset out_quot got %h want 0", out_quot); end
    n_tests++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset out_tag got %h want 0", out_tag); end
    n_tests++; if ({out_dbz, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset dbz/ovf got %b%b want 00", out_dbz, out_ovf); end
  endtask

  task automatic test_directed();
    int nums [6] = '{768, -768, 768, -65536, -65536, 65535};
    int dens [6] = '{2, 2, -7, -1, 1, -256};
`ifdef FXP_DIV_ROUND_EN
    int expq [6] = '{384, -384, -110, 65535, -65536, -256};
`else
    int expq [6] = '{384, -384, -109, 65535, -65536, -255};
`endif
    bit expo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [OW-1:0] eq;
    for (int i = 0; i < 6; i++) begin
      issue(NW'(nums[i]), DW'(dens[i]), TW'(i + 1));
      wait_valid(lat);
      eq = OW'(expq[i]);
      n_tests++; if (out_quot !== eq) begin n_fail++; $display("FAIL directed[%0d] quot got %h want %h", i, out_quot, eq); end
      n_tests++; if (out_ovf !== expo[i]) begin n_fail++; $display("FAIL directed[%0d] ovf got %b want %b", i, out_ovf, expo[i]); end
      n_tests++; if (out_dbz !== 1'b0) begin n_fail++; $display("FAIL directed[%0d] dbz got %b want 0", i, out_dbz); end
      n_tests++; if (out_tag !== TW'(i + 1)) begin n_fail++; $display("FAIL directed[%0d] tag got %h want %h", i, out_tag, TW'(i + 1)); end
      n_tests++; if (lat != QW + 2) begin n_fail++; $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, QW + 2); end
      handoff();
    end
  endtask

  task automatic test_dbz();
    int nums [3] = '{100, -5, 0};
    int expq [3] = '{65535, -65536, 0};
    int lat;
    logic [OW-1:0] eq;
    for (int i = 0; i < 3; i++) begin
      issue(NW'(nums[i]), '0, TW'(i + 8));
      wait_valid(lat);
      eq = OW'(expq[i]);
      n_tests++; if (out_quot !== eq) begin n_fail++; $display("FAIL dbz[%0d] quot got %h want %h", i, out_quot, eq); end
      n_tests++; if ({out_dbz, out_ovf} !== 2'b10) begin n_fail++; $display("FAIL dbz[%0d] dbz/ovf got %b%b want 10", i, out_dbz, out_ovf); end
      n_tests++; if (out_tag !== TW'(i + 8)) begin n_fail++; $display("FAIL dbz[%0d] tag got %h want %h", i, out_tag, TW'(i + 8)); end
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL dbz[%0d] latency got %0d want 1", i, lat); end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [OW-1:0] eq;
    logic ed, eo;
    model(1234, -37, eq, ed, eo);
    issue(NW'(1234), DW'(-37), 4'hA);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] out_valid got %b want 1", c, out_valid); end
      n_tests++; if (out_quot !== eq) begin n_fail++; $display("FAIL hold[%0d] quot got %h want %h", c, out_quot, eq); end
      n_tests++; if (out_tag !== 4'hA) begin n_fail++; $display("FAIL hold[%0d] tag got %h want a", c, out_tag); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] in_ready got %b want 0", c, in_ready); end
    end
    handoff();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, pulses = 0, gap_bad = 0, rdy_bad = 0, lat;
    logic [OW-1:0] eq;
    logic ed, eo;
    model(1000, 3, eq, ed, eo);
    in_num = NW'(1000); in_den = DW'(3); in_tag = 4'h3;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 62; c++) begin
      if (out_valid) begin
        if (in_ready) rdy_bad++;
        if (out_quot !== eq) gap_bad++;
        if (first < 0) first = c;
        else if (c - last != QW + 3) gap_bad++;
        last = c;
        pulses++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    wait_valid(lat);
    handoff();
    n_tests++; if (pulses != 3) begin n_fail++; $display("FAIL b2b pulses got %0d want 3", pulses); end
    n_tests++; if (first != QW + 2) begin n_fail++; $display("FAIL b2b first result cycle got %0d want %0d", first, QW + 2); end
    n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b spacing/value errors got %0d want 0", gap_bad); end
    n_tests++; if (rdy_bad != 0) begin n_fail++; $display("FAIL b2b in_ready during handoff got %0d want 0", rdy_bad); end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic [OW-1:0] eq;
    logic ed, eo;
    for (int i = 0; i < 30; i++) begin
      n = NW'($urandom);
      d = DW'($urandom);
      t = TW'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      model(longint'($signed(n)), longint'($signed(d)), eq, ed, eo);
      elat = (d == '0) ? 1 : QW + 2;
      issue(n, d, t);
      wait_valid(lat);
      n_tests++; if (out_quot !== eq) begin n_fail++; $display("FAIL rand[%0d] %h/%h quot got %h want %h", i, n, d, out_quot, eq); end
      n_tests++; if ({out_dbz, out_ovf} !== {ed, eo}) begin n_fail++; $display("FAIL rand[%0d] dbz/ovf got %b%b want %b%b", i, out_dbz, out_ovf, ed, eo); end
      n_tests++; if (out_tag !== t) begin n_fail++; $display("FAIL rand[%0d] tag got %h want %h", i, out_tag, t); end
      n_tests++; if (lat != elat) begin n_fail++; $display("FAIL rand[%0d] latency got %0d want %0d", i, lat, elat); end
      for (int w = $urandom_range(0, 3); w > 0; w--) tick();
      handoff();
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0, lat;
    logic [OW-1:0] eq;
    logic ed, eo;
    issue(NW'(500), DW'(3), 4'h5);
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid got %b want 0", out_valid); end
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen++;
      tick();
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL reset_mid stray results got %0d want 0", seen); end
    model(-20000, 77, eq, ed, eo);
    issue(NW'(-20000), DW'(77), 4'h6);
    wait_valid(lat);
    n_tests++; if (out_quot !== eq) begin n_fail++; $display("FAIL reset_mid_after quot got %h want %h", out_quot, eq); end
    n_tests++; if (out_tag !== 4'h6) begin n_fail++; $display("FAIL reset_mid_after tag got %h want 6", out_tag); end
    n_tests++; if (lat != QW + 2) begin n_fail++; $display("FAIL reset_mid_after latency got %0d want %0d", lat, QW + 2); end
    handoff();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_num = '0; in_den = '0; in_tag = '0;
    test_reset();
    test_directed();
    test_dbz();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
